uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receiver for the 7-bit-plus-parity UART link; it pairs with the uart transmitter on the same link.
- Oversamples rx_in with a bit-period counter at the system clock (10 MHz nominal, 521 clocks/bit ≈ 19200 baud).
- Frame format: start bit (0), 7 data bits LSB first, even parity bit, 1 stop bit (1). Line idles high.
- Delivers the received word with a one-cycle valid strobe and parity/framing status.

Parameters:
- CLKS_PER_BIT, 521, system clocks per serial bit; must be ≥ 8.
- HALF_BIT, CLKS_PER_BIT/2 (260), clocks from the detected start edge to the start-bit mid-sample.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_in  input  1  asynchronous serial line, idle high.
- dataout_rx  output  7  last received data word, held until the next frame completes.
- data_valid_rx  output  1  one-cycle pulse when dataout_rx and the status outputs update.
- parity_received  output  1  parity bit sampled from the last frame.
- parity_error_rx  output  1  1 if (^dataout_rx) ^ parity_received != 0; held with the frame.
- framing_error_rx  output  1  1 if the last frame's stop bit sampled 0; held with the frame.
- busy_rx  output  1  high from start-edge detection until the receiver returns to IDLE.

Behaviour:
- Reset (async, rst=1):
  - All outputs go to 0.
  - The synchronizer flops go to 1, so the line reads as idle.
  - State goes to IDLE; the bit counter and bit index go to 0.
  - A reset during any state aborts the frame. No data_valid_rx is issued and the previous dataout is cleared to 0.
- Input path: rx_in passes through a 2-flop synchronizer, giving rx_s. All decisions use rx_s only.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - busy_rx=0.
  - On rx_s==0, go to START, clear the counter, and set busy_rx=1 on the next cycle.
- START:
  - Count to HALF_BIT-1, then sample rx_s.
  - If rx_s==1, the start was a glitch: go to IDLE with no outputs changed.
  - If rx_s==0, clear the counter and go to DATA with bit index 0.
- DATA:
  - At counter==CLKS_PER_BIT-1, sample rx_s into shift bit [index] (LSB first) and clear the counter.
  - After index 6, go to PARITY.
- PARITY: at counter==CLKS_PER_BIT-1, sample the parity bit and go to STOP.
- STOP: at counter==CLKS_PER_BIT-1, sample the stop bit. In the same cycle, register all of the following:
  - dataout_rx ← shift register.
  - parity_received ← sampled parity bit.
  - parity_error_rx ← XOR of the 7 data bits and the parity bit.
  - framing_error_rx ← ~stop sample.
  - data_valid_rx=1 for exactly one cycle.
  - Next state: if stop==1, go to IDLE; if stop==0, go to BREAK.
- BREAK: hold busy_rx=1 until rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering frames.
- Mid-bit sampling:
  - Every sample is taken HALF_BIT + k·CLKS_PER_BIT clocks after the start edge is seen on rx_s.
  - The stop sample (and therefore data_valid_rx) occurs HALF_BIT + 9·CLKS_PER_BIT + 2..3 clocks after the rx_in falling edge. The extra 2..3 clocks are synchronizer latency.
- Back-to-back frames:
  - The next start bit may begin immediately after the stop bit.
  - The receiver returns to IDLE at mid-stop, so it detects the next falling edge with no lost frame.
- Status outputs change only on data_valid_rx cycles. The data is delivered even when an error flag is set.
- Counter width: $clog2(CLKS_PER_BIT) bits. The counter never wraps within a bit because it clears at its terminal count.

Test Plan:
1. Reset, then idle line for 1000 clocks → all outputs 0, busy_rx=0, no data_valid_rx.
2. Send 7'b111_1111 with parity 1 and stop 1, at 100 ns clock and 52100 ns/bit → one data_valid_rx pulse, dataout_rx=7'h7F, parity_received=1, parity_error_rx=0, framing_error_rx=0.
3. Send 7'b101_0101 with parity 0, followed back-to-back by 7'b000_0001 with parity 1 → two pulses; dataout_rx=7'h55 then 7'h01; no errors.
4. Send 7'h55 with a wrong parity bit of 1 → dataout_rx=7'h55, parity_error_rx=1, framing_error_rx=0.
5. Send 7'h2A with stop bit 0, then hold the line low for 3 bit times, then release → framing_error_rx=1 and a single data_valid_rx pulse. busy_rx stays 1 until the line goes high; no second frame is decoded.
6. Two glitch/reset checks:
   - A 100-clock low glitch on an idle line → no data_valid_rx and busy_rx returns to 0 at about 262 clocks.
   - rst asserted during DATA bit 3 → outputs 0 immediately. A following clean frame of 7'h7F decodes correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 7-data-bit, even-parity UART receiver with mid-bit sampling
// and held parity/framing status.
module uart_rx #(
  parameter int CLKS_PER_BIT = 521,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [6:0] dataout_rx,
  output logic       data_valid_rx,
  output logic       parity_received,
  output logic       parity_error_rx,
  output logic       framing_error_rx,
  output logic       busy_rx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t        state_q, state_d;
  logic          sync_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    shift_q, shift_d, dout_q, dout_d;
  logic          par_q, par_d, prx_q, prx_d, perr_q, perr_d, ferr_q, ferr_d, valid_q, valid_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      prx_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= rx_in;
      rx_s_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      prx_q   <= prx_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    dout_d  = dout_q;
    prx_d   = prx_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rx_s_q ? IDLE : START;
      end
      START: if (cnt_q == HALF_END) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == BIT_END) begin
        cnt_d          = '0;
        shift_d[idx_q] = rx_s_q;
        idx_d          = idx_q + 3'd1;
        state_d        = (idx_q == 3'd6) ? PARITY : DATA;
      end
      PARITY: if (cnt_q == BIT_END) begin
        cnt_d   = '0;
        par_d   = rx_s_q;
        state_d = STOP;
      end
      STOP: if (cnt_q == BIT_END) begin
        cnt_d   = '0;
        dout_d  = shift_q;
        prx_d   = par_q;
        perr_d  = (^shift_q) ^ par_q;
        ferr_d  = ~rx_s_q;
        valid_d = 1'b1;
        // Returning at mid-stop leaves half a bit to catch a back-to-back start edge.
        state_d = rx_s_q ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_d   = '0;
        state_d = rx_s_q ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
  end
  assign dataout_rx       = dout_q;
  assign data_valid_rx    = valid_q;
  assign parity_received  = prx_q;
  assign parity_error_rx  = perr_q;
  assign framing_error_rx = ferr_q;
  assign busy_rx          = (state_q != IDLE);
endmodule
